// File: rtl/ggt_arbiter_pkg.sv
// Shared types and defaults for the GCD core arbiter.
package ggt_arbiter_pkg;

  localparam int unsigned GGT_W_DEF       = 16;
  localparam int unsigned GGT_TIMEOUT_DEF = 70000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_BUSY   = 3'd3,
    S_FLUSH  = 3'd4,
    S_BYPASS = 3'd5,
    S_DONE   = 3'd6
  } ggt_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ggt_rr_arb.sv
// Combinational round-robin picker: first requester after ptr wins.
module ggt_rr_arb import ggt_arbiter_pkg::*; #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  int unsigned   j;
  logic [IW-1:0] jj;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j  = (32'(ptr) + k) % N_REQ;
      jj = IW'(j);
      if (!valid && req[jj]) begin
        valid     = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/ggt_arbiter.sv
// Shares one ggt_top GCD core between N_REQ requesters; zero operands are
// answered locally and a watchdog flushes a core that never reports valid.
module ggt_arbiter import ggt_arbiter_pkg::*; #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = GGT_W_DEF,
  parameter int unsigned TIMEOUT = GGT_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] zahl1_i,
  input  logic [N_REQ*W-1:0] zahl2_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [W-1:0]       ergebnis_o,
  output logic               err_o,
  output logic               core_start_o,
  output logic [W-1:0]       core_zahl1_o,
  output logic [W-1:0]       core_zahl2_o,
  output logic               core_rst_o,
  input  logic               core_valid_i,
  input  logic [W-1:0]       core_ergebnis_i
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  ggt_state_e       state;
  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] cur_gnt;
  logic [W-1:0]     result;
  logic [CW-1:0]    cnt;

  logic [N_REQ-1:0] win_gnt;
  logic [IW-1:0]    win_idx;
  logic             win_vld;
  logic [W-1:0]     win_a;
  logic [W-1:0]     win_b;

  ggt_rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (win_gnt),
    .idx   (win_idx),
    .valid (win_vld)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_gnt[i]) begin
        win_a = win_a | zahl1_i[i*W +: W];
        win_b = win_b | zahl2_i[i*W +: W];
      end
    end
  end

  assign core_rst_o = rst_i || (state == S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state        <= S_IDLE;
      rr_ptr       <= IW'(N_REQ - 1);
      cur_gnt      <= '0;
      result       <= '0;
      cnt          <= '0;
      ack_o        <= '0;
      done_o       <= '0;
      ergebnis_o   <= '0;
      err_o        <= 1'b0;
      core_start_o <= 1'b0;
      core_zahl1_o <= '0;
      core_zahl2_o <= '0;
    end else begin
      ack_o        <= '0;
      done_o       <= '0;
      err_o        <= 1'b0;
      core_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            rr_ptr  <= win_idx;
            cur_gnt <= win_gnt;
            ack_o   <= win_gnt;
            if ((win_a != '0) && (win_b != '0)) begin
              state        <= S_LAUNCH;
              core_start_o <= 1'b1;
              core_zahl1_o <= win_a;
              core_zahl2_o <= win_b;
            end else begin
              state  <= S_BYPASS;
              result <= win_a | win_b;
            end
          end
        end
        S_LAUNCH: state <= S_ARM;
        // Valid is ignored here so a result left over from the last job is rejected.
        S_ARM: begin
          cnt   <= '0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (core_valid_i) begin
            result     <= core_ergebnis_i;
            ergebnis_o <= core_ergebnis_i;
            done_o     <= cur_gnt;
            state      <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= S_FLUSH;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          result     <= '0;
          ergebnis_o <= '0;
          err_o      <= 1'b1;
          done_o     <= cur_gnt;
          state      <= S_DONE;
        end
        S_BYPASS: begin
          ergebnis_o <= result;
          done_o     <= cur_gnt;
          state      <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ggt_arbiter.sv
// Directed bench for ggt_arbiter with a behavioural GCD core stub and a job-level model.
module tb_ggt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 20;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_STALE  = 1;
  localparam int MODE_STUCK  = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [N-1:0]     req_i = '0;
  logic [N*W-1:0]   zahl1_i = '0;
  logic [N*W-1:0]   zahl2_i = '0;
  logic [N-1:0]     ack_o;
  logic [N-1:0]     done_o;
  logic [W-1:0]     ergebnis_o;
  logic             err_o;
  logic             core_start_o;
  logic [W-1:0]     core_zahl1_o;
  logic [W-1:0]     core_zahl2_o;
  logic             core_rst_o;
  logic             core_valid = 1'b0;
  logic [W-1:0]     core_res = '0;

  ggt_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .zahl1_i         (zahl1_i),
    .zahl2_i         (zahl2_i),
    .ack_o           (ack_o),
    .done_o          (done_o),
    .ergebnis_o      (ergebnis_o),
    .err_o           (err_o),
    .core_start_o    (core_start_o),
    .core_zahl1_o    (core_zahl1_o),
    .core_zahl2_o    (core_zahl2_o),
    .core_rst_o      (core_rst_o),
    .core_valid_i    (core_valid),
    .core_ergebnis_i (core_res)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core stub: fixed latency after start; stale mode keeps a bogus valid through ARM.
  int           core_mode = MODE_NORMAL;
  int           lat = 4;
  int           left = 0;
  logic         stale_hold = 1'b0;
  logic [W-1:0] g_res = '0;

  always @(posedge clk) begin
    if (core_rst_o) begin
      core_valid <= 1'b0;
      core_res   <= '0;
      left       <= 0;
      stale_hold <= 1'b0;
    end else if (core_start_o) begin
      g_res <= gcd(core_zahl1_o, core_zahl2_o);
      if (core_mode == MODE_STALE) begin
        core_valid <= 1'b1;
        core_res   <= 16'hDEAD;
        stale_hold <= 1'b1;
        left       <= lat + 1;
      end else begin
        core_valid <= 1'b0;
        left       <= (core_mode == MODE_STUCK) ? 0 : lat;
      end
    end else begin
      if (stale_hold) begin
        core_valid <= 1'b0;
        stale_hold <= 1'b0;
      end
      if (left == 1) begin
        core_valid <= 1'b1;
        core_res   <= g_res;
        left       <= 0;
      end else if (left > 1) begin
        left <= left - 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job-level model state
  int           m_cyc = 0;
  bit           m_busy = 1'b0;
  int           m_ptr = N - 1;
  int           m_t0 = 0;
  int           m_w = 0;
  int           m_exp_d = 0;
  bit           m_bypass = 1'b0;
  bit           m_stuck = 1'b0;
  logic [N-1:0] m_onehot = '0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_last_res = '0;
  int           jobs_done = 0;
  int           starts = 0;
  int           crsts = 0;
  int           last_idx = -1;
  logic [W-1:0] last_res = '0;
  logic         last_err = 1'b0;
  int           grant_log[$];

  task automatic cmp_cycle();
    int d;
    bit found;
    int j;
    logic [N-1:0] exp_ack;
    m_cyc++;
    if (rst_i) begin
      m_busy     = 1'b0;
      m_ptr      = N - 1;
      m_last_res = '0;
      return;
    end
    if (core_start_o) starts++;
    if (core_rst_o) crsts++;
    if (m_busy) begin
      d = m_cyc - m_t0;
      exp_ack = (d == 1) ? m_onehot : '0;
      chk(ack_o == exp_ack, "ack", longint'(ack_o), longint'(exp_ack));
      chk(core_start_o == ((d == 1) && !m_bypass), "core_start", longint'(core_start_o),
          longint'((d == 1) && !m_bypass));
      chk(core_rst_o == (m_stuck && (d == TO + 3)), "core_rst", longint'(core_rst_o),
          longint'(m_stuck && (d == TO + 3)));
      if (d == 1 && !m_bypass)
        chk(core_zahl1_o == m_a && core_zahl2_o == m_b, "core_operands",
            longint'({core_zahl1_o, core_zahl2_o}), longint'({m_a, m_b}));
      if (done_o != '0 || (m_exp_d != 0 && d == m_exp_d)) begin
        chk(done_o == m_onehot, "done_vec", longint'(done_o), longint'(m_onehot));
        if (m_exp_d != 0) chk(d == m_exp_d, "done_latency", d, m_exp_d);
        chk(ergebnis_o == m_res, "result", longint'(ergebnis_o), longint'(m_res));
        chk(err_o == m_stuck, "err", longint'(err_o), longint'(m_stuck));
        m_busy     = 1'b0;
        m_last_res = m_res;
        last_idx   = m_w;
        last_res   = ergebnis_o;
        last_err   = err_o;
        jobs_done++;
      end else if (d > int'(TO) + 12) begin
        chk(1'b0, "done_timeout", d, m_exp_d);
        m_busy = 1'b0;
      end
    end else begin
      chk(ack_o == '0 && done_o == '0 && !err_o && !core_start_o && !core_rst_o
          && ergebnis_o == m_last_res, "idle_outputs",
          longint'({ack_o, done_o, err_o, core_start_o, core_rst_o, ergebnis_o}),
          longint'(m_last_res));
      found = 1'b0;
      for (int k = 1; k <= int'(N); k++) begin
        j = (m_ptr + k) % int'(N);
        if (!found && req_i[j]) begin
          found = 1'b1;
          m_w   = j;
        end
      end
      if (found) begin
        m_ptr    = m_w;
        m_t0     = m_cyc;
        m_busy   = 1'b1;
        m_onehot = '0;
        m_onehot[m_w] = 1'b1;
        m_a      = zahl1_i[m_w*W +: W];
        m_b      = zahl2_i[m_w*W +: W];
        m_bypass = (m_a == '0) || (m_b == '0);
        m_stuck  = !m_bypass && (core_mode == MODE_STUCK);
        m_res    = m_stuck ? '0 : gcd(m_a, m_b);
        if (m_bypass) m_exp_d = 2;
        else if (m_stuck) m_exp_d = TO + 4;
        else if (core_mode == MODE_STALE) m_exp_d = 0;
        else m_exp_d = 3 + lat;
        grant_log.push_back(m_w);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (ack_o[i]) req_i[i] = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    zahl1_i[i*W +: W] = a;
    zahl2_i[i*W +: W] = b;
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int n;
    n = 0;
    while (jobs_done < target && n < budget) begin
      step();
      n++;
    end
    chk(jobs_done >= target, "job_wait", jobs_done, target);
  endtask

  task automatic chk_order(input int base, input int a0, input int a1, input int a2, input int a3,
                           input int cnt);
    int exp_q[4];
    exp_q = '{a0, a1, a2, a3};
    for (int i = 0; i < cnt; i++) begin
      if (grant_log.size() > base + i)
        chk(grant_log[base + i] == exp_q[i], "grant_order", grant_log[base + i], exp_q[i]);
      else
        chk(1'b0, "grant_missing", grant_log.size(), base + i + 1);
    end
  endtask

  initial begin
    int base, st, cr, jd, n;

    // Reset state
    rst_i = 1'b1;
    repeat (3) step();
    chk(ack_o == '0 && done_o == '0 && !err_o && !core_start_o && ergebnis_o == '0
        && core_zahl1_o == '0 && core_zahl2_o == '0, "reset_outputs",
        longint'({ack_o, done_o, err_o, core_start_o, ergebnis_o}), 0);
    chk(core_rst_o == 1'b1, "reset_core_rst", longint'(core_rst_o), 1);
    rst_i = 1'b0;

    // Single job through the core
    set_op(0, 16'd24255, 16'd12540);
    req_i[0] = 1'b1;
    wait_jobs(1, 200);
    chk(last_idx == 0, "single_idx", last_idx, 0);
    chk(last_res == 16'd165, "single_result", longint'(last_res), 165);
    chk(last_err == 1'b0, "single_err", longint'(last_err), 0);
    chk(starts == 1, "single_starts", starts, 1);

    // Fairness from reset
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    set_op(0, 16'd12, 16'd18);
    set_op(1, 16'd35, 16'd14);
    set_op(2, 16'd0, 16'd9);
    set_op(3, 16'd100, 16'd75);
    base = grant_log.size();
    req_i = 4'b1111;
    wait_jobs(jobs_done + 4, 400);
    chk_order(base, 0, 1, 2, 3, 4);
    chk(last_res == 16'd25, "fair_last_result", longint'(last_res), 25);
    set_op(0, 16'd21, 16'd14);
    set_op(2, 16'd8, 16'd12);
    base = grant_log.size();
    req_i = 4'b0101;
    wait_jobs(jobs_done + 2, 200);
    chk_order(base, 0, 2, 0, 0, 2);
    chk(last_res == 16'd4, "fair2_result", longint'(last_res), 4);

    // Zero operands bypass the core
    st = starts;
    set_op(1, 16'd0, 16'd48);
    req_i[1] = 1'b1;
    wait_jobs(jobs_done + 1, 50);
    chk(last_res == 16'd48, "bypass_result_48", longint'(last_res), 48);
    chk(last_idx == 1, "bypass_idx", last_idx, 1);
    set_op(1, 16'd0, 16'd0);
    req_i[1] = 1'b1;
    wait_jobs(jobs_done + 1, 50);
    chk(last_res == 16'd0, "bypass_result_0", longint'(last_res), 0);
    chk(starts == st, "bypass_no_start", starts, st);

    // Stale valid through LAUNCH/ARM must be rejected
    core_mode = MODE_STALE;
    set_op(3, 16'd48, 16'd18);
    req_i[3] = 1'b1;
    wait_jobs(jobs_done + 1, 100);
    chk(last_res == 16'd6, "stale_result", longint'(last_res), 6);
    core_mode = MODE_NORMAL;

    // Watchdog on a stuck core, then recovery
    core_mode = MODE_STUCK;
    cr = crsts;
    set_op(2, 16'd7, 16'd5);
    req_i[2] = 1'b1;
    wait_jobs(jobs_done + 1, 100);
    chk(last_err == 1'b1, "timeout_err", longint'(last_err), 1);
    chk(last_res == 16'd0, "timeout_result", longint'(last_res), 0);
    chk(crsts - cr == 1, "timeout_core_rst_pulses", crsts - cr, 1);
    core_mode = MODE_NORMAL;
    set_op(2, 16'd9, 16'd6);
    req_i[2] = 1'b1;
    wait_jobs(jobs_done + 1, 100);
    chk(last_res == 16'd3 && last_err == 1'b0, "recover_result",
        longint'({last_err, last_res}), 3);

    // Reset while BUSY
    lat = 10;
    set_op(1, 16'd30, 16'd20);
    req_i[1] = 1'b1;
    n = 0;
    while (!ack_o[1] && n < 10) begin
      step();
      n++;
    end
    chk(ack_o[1] == 1'b1, "midjob_ack", longint'(ack_o), 2);
    repeat (3) step();
    jd = jobs_done;
    rst_i = 1'b1;
    step();
    chk(ack_o == '0 && done_o == '0 && !err_o && !core_start_o && ergebnis_o == '0
        && core_zahl1_o == '0 && core_zahl2_o == '0, "midjob_reset_outputs",
        longint'({ack_o, done_o, err_o, core_start_o, ergebnis_o}), 0);
    rst_i = 1'b0;
    lat = 4;
    set_op(0, 16'd27, 16'd18);
    set_op(3, 16'd14, 16'd21);
    base = grant_log.size();
    req_i = 4'b1001;
    wait_jobs(jd + 2, 200);
    chk_order(base, 0, 3, 0, 0, 2);
    chk(jobs_done == jd + 2, "midjob_no_done", jobs_done, jd + 2);
    chk(last_res == 16'd7, "post_reset_result", longint'(last_res), 7);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
